// File: rtl/b09_rx_pkg.sv
// Shared types and line levels for the b09 serial receiver.
// Imported by the FIFO and the deserializer top level.
package b09_rx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        STOP
    } rx_state_t;

    localparam logic START_LVL = 1'b1;
    localparam logic STOP_LVL  = 1'b0;
    localparam logic IDLE_LVL  = 1'b0;

    localparam int DEF_DATA_W = 8;

endpackage

// File: rtl/b09_rx_fifo.sv
// Small synchronous FIFO; a push into a full FIFO is taken only
// when a pop frees the head slot on the same edge.
module b09_rx_fifo
    import b09_rx_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              empty,
    output logic              full,
    output logic              push_ok
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic              do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign push_ok = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push_ok, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/b09_rx_deser.sv
// Frame hunter and deserializer for the converter's Y line:
// start 1, DATA_W bits MSB first, stop 0, buffered on valid/ready.
module b09_rx_deser
    import b09_rx_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int FIFO_DEPTH = 2,
    parameter int CNT_W      = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              y_in,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              frame_err,
    output logic              overrun,
    output logic [CNT_W-1:0]  frame_cnt,
    output logic [CNT_W-1:0]  drop_cnt,
    output logic              busy
);

    localparam int BW = $clog2(DATA_W);

    rx_state_t         state;
    rx_state_t         state_nxt;
    logic [DATA_W-1:0] shreg;
    logic [BW-1:0]     bit_cnt;
    logic              push;
    logic              push_ok;
    logic              err;
    logic              empty;
    logic              full;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        err       = 1'b0;
        unique case (state)
            IDLE: begin
                if (y_in == START_LVL) state_nxt = DATA;
            end
            DATA: begin
                if (bit_cnt == BW'(DATA_W-1)) state_nxt = STOP;
            end
            STOP: begin
                // a 1 here is a bad stop, never a new start
                state_nxt = IDLE;
                if (y_in == STOP_LVL) push = 1'b1;
                else                  err  = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (state == DATA) begin
            shreg   <= {shreg[DATA_W-2:0], y_in};
            bit_cnt <= bit_cnt + 1'b1;
        end else begin
            bit_cnt <= '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            frame_cnt <= '0;
            drop_cnt  <= '0;
        end else begin
            frame_err <= err;
            overrun   <= push & ~push_ok;
            if (push_ok && frame_cnt != '1) begin
                frame_cnt <= frame_cnt + 1'b1;
            end
            if (push && !push_ok && drop_cnt != '1) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end

    b09_rx_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (shreg),
        .pop       (out_valid & out_ready),
        .head      (out_data),
        .empty     (empty),
        .full      (full),
        .push_ok   (push_ok)
    );

    assign out_valid = ~empty;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_b09_rx_deser.sv
// Directed bench for b09_rx_deser with hand-computed expectations.
// Inputs change and outputs are sampled 1 time unit after each edge.
module tb_b09_rx_deser;

    logic       clock;
    logic       reset;
    logic       y_in;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       frame_err;
    logic       overrun;
    logic [7:0] frame_cnt;
    logic [7:0] drop_cnt;
    logic       busy;

    int checks;
    int failures;

    b09_rx_deser #(
        .DATA_W     (8),
        .FIFO_DEPTH (2),
        .CNT_W      (8)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .y_in      (y_in),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .frame_cnt (frame_cnt),
        .drop_cnt  (drop_cnt),
        .busy      (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        y_in = b;
        @(posedge clock);
        #1;
    endtask

    // start bit plus data bits; the caller sends the stop bit
    task automatic send_head(input logic [7:0] d);
        send_bit(1'b1);
        for (int i = 7; i >= 0; i--) begin
            send_bit(d[i]);
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        reset     = 1'b1;
        y_in      = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;

        // idle after reset
        repeat (20) send_bit(1'b0);
        chk("idle_valid", {31'd0, out_valid}, 32'd0);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_fcnt", {24'd0, frame_cnt}, 32'd0);
        chk("idle_dcnt", {24'd0, drop_cnt}, 32'd0);
        chk("idle_data", {24'd0, out_data}, 32'd0);
        chk("idle_ferr", {31'd0, frame_err}, 32'd0);

        // clean frame 0xA5
        out_ready = 1'b1;
        send_head(8'hA5);
        chk("a5_busy", {31'd0, busy}, 32'd1);
        chk("a5_prevalid", {31'd0, out_valid}, 32'd0);
        send_bit(1'b0);
        chk("a5_valid", {31'd0, out_valid}, 32'd1);
        chk("a5_data", {24'd0, out_data}, 32'hA5);
        chk("a5_fcnt", {24'd0, frame_cnt}, 32'd1);
        chk("a5_busy_end", {31'd0, busy}, 32'd0);
        send_bit(1'b0);
        chk("a5_drained", {31'd0, out_valid}, 32'd0);

        // bad stop bit on 0x3C, then clean 0x81
        send_head(8'h3C);
        send_bit(1'b1);
        chk("3c_ferr", {31'd0, frame_err}, 32'd1);
        chk("3c_valid", {31'd0, out_valid}, 32'd0);
        chk("3c_fcnt", {24'd0, frame_cnt}, 32'd1);
        chk("3c_nostart", {31'd0, busy}, 32'd0);
        send_bit(1'b0);
        chk("3c_ferr_end", {31'd0, frame_err}, 32'd0);
        chk("3c_idle", {31'd0, busy}, 32'd0);
        send_head(8'h81);
        send_bit(1'b0);
        chk("81_data", {24'd0, out_data}, 32'h81);
        chk("81_valid", {31'd0, out_valid}, 32'd1);
        chk("81_fcnt", {24'd0, frame_cnt}, 32'd2);
        send_bit(1'b0);

        // overrun on third frame with consumer stalled
        out_ready = 1'b0;
        send_head(8'h11);
        send_bit(1'b0);
        send_head(8'h22);
        send_bit(1'b0);
        chk("ovr_head", {24'd0, out_data}, 32'h11);
        send_head(8'h33);
        send_bit(1'b0);
        chk("ovr_pulse", {31'd0, overrun}, 32'd1);
        chk("ovr_dcnt", {24'd0, drop_cnt}, 32'd1);
        chk("ovr_fcnt", {24'd0, frame_cnt}, 32'd4);
        chk("ovr_stable", {24'd0, out_data}, 32'h11);
        send_bit(1'b0);
        chk("ovr_pulse_end", {31'd0, overrun}, 32'd0);
        out_ready = 1'b1;
        send_bit(1'b0);
        chk("ovr_second", {24'd0, out_data}, 32'h22);
        chk("ovr_second_v", {31'd0, out_valid}, 32'd1);
        send_bit(1'b0);
        chk("ovr_empty", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b0;

        // full FIFO, pop coincides with the stop bit of 0x44
        send_head(8'h66);
        send_bit(1'b0);
        send_head(8'h77);
        send_bit(1'b0);
        chk("full_fcnt", {24'd0, frame_cnt}, 32'd6);
        send_head(8'h44);
        out_ready = 1'b1;
        send_bit(1'b0);
        out_ready = 1'b0;
        chk("pp_overrun", {31'd0, overrun}, 32'd0);
        chk("pp_dcnt", {24'd0, drop_cnt}, 32'd1);
        chk("pp_fcnt", {24'd0, frame_cnt}, 32'd7);
        chk("pp_head", {24'd0, out_data}, 32'h77);
        out_ready = 1'b1;
        send_bit(1'b0);
        chk("pp_last", {24'd0, out_data}, 32'h44);
        chk("pp_last_v", {31'd0, out_valid}, 32'd1);
        send_bit(1'b0);
        chk("pp_empty", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b0;

        // reset during data bit 4 with a byte buffered
        send_head(8'h99);
        send_bit(1'b0);
        chk("rst_pre_valid", {31'd0, out_valid}, 32'd1);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        reset = 1'b1;
        send_bit(1'b1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_fcnt", {24'd0, frame_cnt}, 32'd0);
        chk("rst_dcnt", {24'd0, drop_cnt}, 32'd0);
        reset = 1'b0;
        repeat (12) send_bit(1'b0);
        chk("rst_ferr", {31'd0, frame_err}, 32'd0);
        chk("rst_ovr", {31'd0, overrun}, 32'd0);
        chk("rst_idle", {31'd0, busy}, 32'd0);
        out_ready = 1'b1;
        send_head(8'hFF);
        send_bit(1'b0);
        chk("ff_data", {24'd0, out_data}, 32'hFF);
        chk("ff_valid", {31'd0, out_valid}, 32'd1);
        chk("ff_fcnt", {24'd0, frame_cnt}, 32'd1);
        send_bit(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/b09_rx_deser.md
Name: b09_rx_deser

Overview:
- Downstream consumer of the serial-to-serial converter's Y output line.
- Watches the single-bit serial stream, finds framed words, and deserializes them into parallel bytes.
- Buffers completed bytes in a small FIFO and presents them on a valid/ready handshake.
- Flags framing errors and overruns, and keeps saturating statistics counters for frames accepted and bytes dropped.

Parameters:
- DATA_W, 8: data bits per frame (matches the converter's output word width).
- FIFO_DEPTH, 2: output buffer entries; must be a power of 2 and at least 2.
- CNT_W, 8: width of the frame_cnt and drop_cnt statistics counters.

Ports:
- clock  in  1  single clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- y_in  in  1  serial line from the converter; idle level is 0; one bit is sampled per clock.
- out_data  out  DATA_W  oldest buffered byte; bit DATA_W-1 is the first data bit received.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  consumer accepts out_data on a cycle where out_valid & out_ready.
- frame_err  out  1  one-cycle pulse: stop bit sampled as 1.
- overrun  out  1  one-cycle pulse: complete frame dropped because the FIFO was full.
- frame_cnt  out  CNT_W  frames pushed into the FIFO; saturates at all-ones.
- drop_cnt  out  CNT_W  frames dropped by overrun; saturates at all-ones.
- busy  out  1  receiver state is not IDLE.

Behaviour:
- Reset is synchronous and active-high on clock; there is a single clock.
- Values forced by reset: state IDLE, FIFO empty, out_valid 0, out_data 0, frame_err 0, overrun 0, frame_cnt 0, drop_cnt 0, busy 0.
- Frame format: start bit 1, then DATA_W data bits MSB first, then stop bit 0. A frame is DATA_W+2 cycles.
- State machine:
  - IDLE: y_in=1 -> DATA with bit_cnt cleared; y_in=0 -> stay in IDLE.
  - DATA: shift y_in into shift register at the LSB end and increment bit_cnt. After DATA_W bits have been shifted -> STOP.
  - STOP, y_in=0 -> push the shift register into the FIFO, or drop it if the push is refused -> IDLE.
  - STOP, y_in=1 -> pulse frame_err, discard the word -> IDLE. That 1 is NOT treated as a start bit; no back-to-back start.
- Latency: stop bit sampled at edge k -> byte in FIFO and out_valid=1 in cycle k+1 when the FIFO was empty. frame_err, overrun and counter updates are also registered at edge k.
- Push when FIFO full:
  - Accepted only if a pop occurs in the same cycle (out_valid & out_ready).
  - Otherwise the byte is dropped, overrun pulses, and drop_cnt increments.
- Simultaneous push and pop on an empty FIFO: impossible, since out_valid=0 means no pop; the push proceeds normally.
- FIFO order is first-in first-out. Read and write pointers are log2(FIFO_DEPTH) bits and wrap naturally. Full/empty is decided by an occupancy count of log2(FIFO_DEPTH)+1 bits.
- out_data is stable while out_valid & !out_ready.
- frame_cnt increments on every accepted push; drop_cnt on every drop. Both hold at all-ones once saturated.
- busy = (state != IDLE), registered with the state.
- Reset mid-frame discards the partial word and empties the FIFO; no pulses are generated.
- y_in is already synchronous to clock; there is no metastability stage in this block.

Decomposition:
- Package b09_rx_pkg holds:
  - state enum {IDLE, DATA, STOP};
  - constants START_LVL=1, STOP_LVL=0, IDLE_LVL=0;
  - default DATA_W.
- Sub-module b09_rx_fifo is a parameterised synchronous FIFO:
  - inputs: push, push_data, pop;
  - outputs: head, empty, full;
  - the simultaneous push+pop-when-full rule lives inside it.
- The top level holds the FSM, shift register, bit counter, pulses and statistics.

Test Plan:
- Reset, y_in=0 for 20 cycles -> out_valid=0, busy=0, counters 0.
- Frame 1,1010_0101,0 with out_ready=1 -> out_data=0xA5 with out_valid=1 exactly one cycle after the stop bit; frame_cnt=1.
- Frame 1,0x3C bits,1 (bad stop) -> frame_err pulses for 1 cycle, no push, frame_cnt unchanged; the next clean frame with 0x81 is received correctly.
- out_ready=0, send frames 0x11, 0x22, 0x33 -> FIFO holds 0x11 then 0x22; overrun pulses on the third stop bit; drop_cnt=1. Raising out_ready then yields 0x11, 0x22 in order.
- FIFO full, out_ready=1 on the exact cycle the stop bit of 0x44 is sampled -> pop and push both occur, no overrun, and 0x44 is delivered after the remaining entries.
- Assert reset during data bit 4 of a frame -> busy=0 next cycle, FIFO empty, no frame_err/overrun; the subsequent frame 0xFF is received normally.
